// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshake and iterative shifter
//
// Purpose:
//   Logic, arithmetic and compare ops complete one cycle after accept.
//   Shifts run one bit per cycle through the SHIFT state. When the macro
//   ALU_FAST_SHIFT_EN is defined, shifts use a barrel shifter and complete
//   like every other op. The SHIFT state is then never entered.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   request valid            in_ready   unit idle, can accept
//   ALUCtrl    5-bit operation code     Sign       signed slt/overflow select
//   in_a       operand A                in_b       operand B (shifted operand)
//   shamt      shift amount
//   out_valid  result valid             out_ready  consumer accepts result
//   result     32-bit result            zero       result == 0
//   overflow   signed add/sub overflow (Sign = 1 only)
module alu_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         ALUCtrl,
    input  logic               Sign,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               overflow
);

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SLT = 5'b00111;
    localparam logic [4:0] OP_NOR = 5'b01000;
    localparam logic [4:0] OP_XOR = 5'b01001;
    localparam logic [4:0] OP_SLL = 5'b01010;
    localparam logic [4:0] OP_SRL = 5'b10000;
    localparam logic [4:0] OP_SRA = 5'b10001;

    localparam logic [1:0] SH_LL = 2'd0;
    localparam logic [1:0] SH_RL = 2'd1;
    localparam logic [1:0] SH_RA = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                r_overflow;
    logic [DATA_W-1:0]   r_shreg;
    logic [SHAMT_W-1:0]  r_cnt;
    logic [1:0]          r_sh_kind;

    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic                w_add_ovf;
    logic                w_sub_ovf;
    logic                w_slt;
    logic                w_is_shift;
    logic [1:0]          w_kind;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_ovf;
    logic [DATA_W-1:0]   w_step;

    assign w_sum  = in_a + in_b;
    assign w_diff = in_a - in_b;

    // Signed overflow: operands agree in sign (add) or differ (sub) and the
    // result's sign departs from A.
    assign w_add_ovf = (in_a[DATA_W-1] == in_b[DATA_W-1]) && (w_sum[DATA_W-1]  != in_a[DATA_W-1]);
    assign w_sub_ovf = (in_a[DATA_W-1] != in_b[DATA_W-1]) && (w_diff[DATA_W-1] != in_a[DATA_W-1]);

    assign w_slt = Sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);

    assign w_is_shift = (ALUCtrl == OP_SLL) || (ALUCtrl == OP_SRL) || (ALUCtrl == OP_SRA);

    always_comb begin
        w_kind = SH_LL;
        if (ALUCtrl == OP_SRL) begin
            w_kind = SH_RL;
        end else if (ALUCtrl == OP_SRA) begin
            w_kind = SH_RA;
        end
    end

    // Single-cycle result. For shifts in the iterative build this is only
    // used when shamt is zero, so B passes straight through.
    always_comb begin
        w_alu_res = w_sum;
        w_alu_ovf = Sign & w_add_ovf;
        case (ALUCtrl)
            OP_AND: begin w_alu_res = in_a & in_b;    w_alu_ovf = 1'b0; end
            OP_OR:  begin w_alu_res = in_a | in_b;    w_alu_ovf = 1'b0; end
            OP_ADD: begin w_alu_res = w_sum;          w_alu_ovf = Sign & w_add_ovf; end
            OP_SUB: begin w_alu_res = w_diff;         w_alu_ovf = Sign & w_sub_ovf; end
            OP_SLT: begin w_alu_res = {{(DATA_W-1){1'b0}}, w_slt}; w_alu_ovf = 1'b0; end
            OP_NOR: begin w_alu_res = ~(in_a | in_b); w_alu_ovf = 1'b0; end
            OP_XOR: begin w_alu_res = in_a ^ in_b;    w_alu_ovf = 1'b0; end
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL: begin w_alu_res = in_b << shamt;  w_alu_ovf = 1'b0; end
            OP_SRL: begin w_alu_res = in_b >> shamt;  w_alu_ovf = 1'b0; end
            OP_SRA: begin w_alu_res = DATA_W'($signed(in_b) >>> shamt); w_alu_ovf = 1'b0; end
`else
            OP_SLL, OP_SRL, OP_SRA: begin w_alu_res = in_b; w_alu_ovf = 1'b0; end
`endif
            default: begin w_alu_res = w_sum; w_alu_ovf = Sign & w_add_ovf; end
        endcase
    end

    // One-bit step of the iterative shifter; sra replicates the sign bit.
    always_comb begin
        w_step = {r_shreg[DATA_W-2:0], 1'b0};
        case (r_sh_kind)
            SH_RL:   w_step = {1'b0, r_shreg[DATA_W-1:1]};
            SH_RA:   w_step = {r_shreg[DATA_W-1], r_shreg[DATA_W-1:1]};
            default: w_step = {r_shreg[DATA_W-2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_sh_kind   <= SH_LL;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
`ifdef ALU_FAST_SHIFT_EN
                        r_result    <= w_alu_res;
                        r_zero      <= (w_alu_res == '0);
                        r_overflow  <= w_alu_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
`else
                        if (w_is_shift && (shamt != '0)) begin
                            r_shreg   <= in_b;
                            r_cnt     <= shamt;
                            r_sh_kind <= w_kind;
                            r_state   <= S_SHIFT;
                        end else begin
                            r_result    <= w_alu_res;
                            r_zero      <= (w_alu_res == '0);
                            r_overflow  <= w_alu_ovf;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
`endif
                    end
                end
                S_SHIFT: begin
                    r_shreg <= w_step;
                    r_cnt   <= r_cnt - SHAMT_W'(1);
                    // Last step lands directly in the result registers.
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_result    <= w_step;
                        r_zero      <= (w_step == '0);
                        r_overflow  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // No accept on the handshake cycle; in_ready rises next cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  ALUCtrl;
    logic        Sign;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUCtrl   (ALUCtrl),
        .Sign      (Sign),
        .in_a      (in_a),
        .in_b      (in_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam logic [4:0] AND_ = 5'b00000, OR_ = 5'b00001, ADD_ = 5'b00010, SUB_ = 5'b00110;
    localparam logic [4:0] SLT_ = 5'b00111, NOR_ = 5'b01000, XOR_ = 5'b01001, SLL_ = 5'b01010;
    localparam logic [4:0] SRL_ = 5'b10000, SRA_ = 5'b10001;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -MAXS - 1;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    bit   seen = 1'b0;
    logic [31:0] last_res;
    logic        last_zero;
    logic        last_ovf;
    int          last_lat;
    int          cur_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit ovf_of(input longint wide);
        return (wide > MAXS) || (wide < MINS);
    endfunction

    // Reference model: outputs follow directly from the operation table.
    function automatic exp_t model(input logic [4:0] op, input logic sgn,
                                   input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        exp_t   e;
        longint sa;
        longint sb;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.ovf = 1'b0;
        e.lat = 1;
        e.acc = 0;
        case (op)
            AND_: e.res = a & b;
            OR_:  e.res = a | b;
            SUB_: begin e.res = a - b; e.ovf = sgn && ovf_of(sa - sb); end
            SLT_: e.res = sgn ? {31'b0, $signed(a) < $signed(b)} : {31'b0, a < b};
            NOR_: e.res = ~(a | b);
            XOR_: e.res = a ^ b;
            SLL_: begin e.res = b << sh; e.lat = FAST ? 1 : int'(sh) + 1; end
            SRL_: begin e.res = b >> sh; e.lat = FAST ? 1 : int'(sh) + 1; end
            SRA_: begin e.res = $unsigned($signed(b) >>> sh); e.lat = FAST ? 1 : int'(sh) + 1; end
            default: begin e.res = a + b; e.ovf = sgn && ovf_of(sa + sb); end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic do_op(input logic [4:0] op, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
            return;
        end
        in_valid = 1'b1;
        ALUCtrl  = op;
        Sign     = sgn;
        in_a     = a;
        in_b     = b;
        shamt    = sh;
        e        = model(op, sgn, a, b, sh);
        e.acc    = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ALUCtrl  = 5'($urandom);
        Sign     = 1'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        shamt    = 5'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d results outstanding, required 0", q.size());
            q.delete();
            seen = 1'b0;
        end
    endtask

    task automatic pin(input string name, input logic [31:0] res, input logic z,
                       input logic ov, input int lat);
        chk({name, "_result"},   last_res, res);
        chk({name, "_zero"},     32'(last_zero), 32'(z));
        chk({name, "_overflow"}, 32'(last_ovf), 32'(ov));
        chk({name, "_latency"},  32'(last_lat), 32'(lat));
    endtask

    // Compare process: every cycle a result is presented it must match the
    // oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: out_valid=1 result=0x%08h with nothing outstanding, required out_valid=0", result);
            end else begin
                if (!seen) begin
                    seen    = 1'b1;
                    cur_lat = cyc - q[0].acc + 1;
                    chk("latency", 32'(cur_lat), 32'(q[0].lat));
                end
                chk("result",   result, q[0].res);
                chk("zero",     32'(zero), 32'(q[0].zero));
                chk("overflow", 32'(overflow), 32'(q[0].ovf));
                chk("in_ready_in_done", 32'(in_ready), 32'd0);
                if (out_ready) begin
                    last_res  = result;
                    last_zero = zero;
                    last_ovf  = overflow;
                    last_lat  = cur_lat;
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ALUCtrl   = 5'd0;
        Sign      = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        shamt     = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_result",    result,         32'd0);
        chk("rst_zero",      32'(zero),      32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(SLT_, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0); wait_done();
        pin("slt_signed", 32'd1, 1'b0, 1'b0, 1);
        do_op(SLT_, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0); wait_done();
        pin("slt_unsigned", 32'd0, 1'b1, 1'b0, 1);

        do_op(ADD_, 1'b1, 32'h7FFF_FFFF, 32'd1, 5'd0); wait_done();
        pin("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1);
        do_op(ADD_, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0); wait_done();
        pin("add_unsigned", 32'h8000_0000, 1'b0, 1'b0, 1);
        do_op(SUB_, 1'b1, 32'h8000_0000, 32'd1, 5'd0); wait_done();
        pin("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1);

        do_op(SRA_, 1'b0, 32'h0, 32'h8000_0000, 5'd4); wait_done();
        pin("sra4", 32'hF800_0000, 1'b0, 1'b0, FAST ? 1 : 5);
        do_op(SRL_, 1'b0, 32'h0, 32'h8000_0000, 5'd4); wait_done();
        pin("srl4", 32'h0800_0000, 1'b0, 1'b0, FAST ? 1 : 5);
        do_op(SLL_, 1'b0, 32'h0, 32'h0000_0001, 5'd31); wait_done();
        pin("sll31", 32'h8000_0000, 1'b0, 1'b0, FAST ? 1 : 32);
        do_op(SLL_, 1'b0, 32'h0, 32'h0000_1234, 5'd0); wait_done();
        pin("sll0", 32'h0000_1234, 1'b0, 1'b0, 1);
        do_op(SRA_, 1'b1, 32'h0, 32'h4000_0000, 5'd3); wait_done();
        do_op(SRL_, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd1); wait_done();

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        do_op(XOR_, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_result",    result,         32'hF0F0_0F0F);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready",  32'(in_ready),  32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        do_op(OR_, 1'b0, 32'h0000_00F0, 32'h0000_0F00, 5'd0); wait_done();
        pin("or_after_bp", 32'h0000_0FF0, 1'b0, 1'b0, 1);

        do_op(5'b11111, 1'b0, 32'd2, 32'd3, 5'd0); wait_done();
        pin("fallback_add", 32'd5, 1'b0, 1'b0, 1);
        do_op(NOR_, 1'b0, 32'd0, 32'd0, 5'd0); wait_done();
        pin("nor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        do_op(AND_, 1'b0, 32'h0000_00F0, 32'h0000_000F, 5'd0); wait_done();
        pin("and", 32'd0, 1'b1, 1'b0, 1);
        do_op(5'b00011, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd0); wait_done();

        // Reset mid-shift: the in-flight operation vanishes.
        do_op(SLL_, 1'b0, 32'h0, 32'd1, 5'd20);
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        q.delete();
        seen = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result",    result,         32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        repeat (25) begin @(posedge clk); #1; end
        do_op(SUB_, 1'b1, 32'd10, 32'd3, 5'd0); wait_done();
        pin("sub_after_rst", 32'd7, 1'b0, 1'b0, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
